key_mode_sequencer: RTL and testbench
=====================================

# key_mode_sequencer

Debounced push-button front end for the DE10-Lite lab designs: synchronizes the two raw active-low KEY inputs to the 50 MHz clock, debounces them, and turns accepted KEY0 presses into a wrapping mode-select count consumed by the display multiplexer. It replaces asynchronous, KEY-clocked mode counting with a single-clock synchronous producer of the mode-select bus. A KEY0 press while KEY1 is held clears the mode to 0.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive clock cycles a synchronized key level must differ from the debounced level before it is accepted (20 ms at 50 MHz); legal range >= 2.
- MODE_COUNT, 4, number of modes; mode wraps from MODE_COUNT-1 to 0; legal range 2..4.
- MAX10_CLK1_50  input  1  50 MHz system clock; all state changes on its rising edge.
- RESET  input  1  reset; synchronous and active-high.
- KEY  input  2  raw board buttons, active-low (0 = pressed), asynchronous to the clock.
- mode  output  2  current mode select, 0..MODE_COUNT-1.
- key_state  output  2  debounced key levels, active-high (1 = pressed).
- step_pulse  output  1  one-cycle strobe when an accepted KEY0 press increments the mode.
- clear_pulse  output  1  one-cycle strobe when an accepted KEY0 press clears the mode.

## Operation
- Per key: 2-flop synchronizer, then inversion to active-high level s[i].
- Per key debounce counter cnt[i], width ceil(log2(DEBOUNCE_CYCLES)):
  - s[i] == key_state[i]: cnt[i] <= 0.
  - s[i] != key_state[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != key_state[i] and cnt[i] == DEBOUNCE_CYCLES-1: key_state[i] <= s[i], cnt[i] <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded and restarts the count.
- Press edge: register prev0 <= key_state[0]; press0 = key_state[0] & ~prev0.
- Mode update on the cycle press0 is high:
  - key_state[1] == 1: mode <= 0, clear_pulse <= 1, step_pulse <= 0.
  - key_state[1] == 0: mode <= (mode == MODE_COUNT-1) ? 0 : mode+1; step_pulse <= 1; clear_pulse <= 0.
- Otherwise step_pulse and clear_pulse are 0 and mode holds.
- KEY0 release, KEY1 press and KEY1 release alone never change mode.
- Simultaneous events: if key_state[1] and key_state[0] become 1 on the same edge, press0 is detected with key_state[1] = 1, so the result is a clear.
- A KEY0 held continuously produces exactly one step; there is no auto-repeat.
- step_pulse and clear_pulse are mutually exclusive.

## Timing
- Reset values (RESET high at a rising edge): synchronizer flops = 1 (released), key_state = 2'b00, prev0 = 0, cnt = 0, mode = 0, step_pulse = 0, clear_pulse = 0.
- RESET overrides all other activity on the same edge; a debounce in progress is abandoned.
- A key held through reset release is seen as a new press once debounced: key_state rises DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Latency from a raw KEY transition that then stays stable:
  - 2 cycles through the synchronizer.
  - DEBOUNCE_CYCLES cycles to key_state change.
  - 1 more cycle to mode/step_pulse/clear_pulse.
  - Total DEBOUNCE_CYCLES+3 cycles from the first sampling edge.
- mode, key_state and both strobes are registered outputs; there are no combinational paths from KEY.
- Minimum accepted press-to-press interval: 2*DEBOUNCE_CYCLES cycles (press, then release).

## Test plan
- Run with DEBOUNCE_CYCLES=4 and MODE_COUNT=4.
- Reset: hold RESET 3 cycles with KEY=2'b00 (both pressed) -> all outputs 0 during reset. After release, key_state=2'b11 at cycle 6, then clear_pulse=1 for 1 cycle and mode stays 0.
- Stepping: five clean KEY0 presses/releases (KEY1 released), each level held 10 cycles -> mode sequence 1,2,3,0,1; exactly five step_pulse strobes, each 7 cycles after the KEY0 fall.
- Bounce: KEY0 toggles low/high every 2 cycles for 12 cycles, then stays high -> key_state[0] stays 0, no strobes, mode unchanged. The same bounce followed by steady low -> exactly one step.
- Clear: step mode to 3, hold KEY1 low for 10 cycles, then press KEY0 -> clear_pulse for 1 cycle, mode=0, no step_pulse. Releasing KEY1 afterwards leaves mode 0.
- Simultaneous: KEY0 and KEY1 fall on the same cycle -> both key_state bits rise together, clear_pulse=1, mode=0.
- Reset mid-debounce: KEY0 falls, RESET pulses 1 cycle at debounce count 2, KEY0 stays low -> key_state[0] rises DEBOUNCE_CYCLES+2 cycles after reset release; one step, mode=1.

Source files
------------

// File: rtl/key_mode_sequencer_if.sv
// Board-side bundle for the key/mode front end: raw active-low KEYs in,
// debounced levels, mode select and strobes out.
interface key_mode_sequencer_if;
    logic [1:0] KEY;
    logic [1:0] mode;
    logic [1:0] key_state;
    logic       step_pulse;
    logic       clear_pulse;

    modport master (output KEY, input mode, key_state, step_pulse, clear_pulse);
    modport slave  (input KEY, output mode, key_state, step_pulse, clear_pulse);
endinterface

// File: rtl/key_mode_sequencer.sv
// Synchronize + debounce two active-low push buttons and turn accepted KEY0
// presses into a wrapping mode count; KEY0 while KEY1 is held clears the mode.
module key_mode_sequencer_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          s;

    assign s = ~sync_q[1];

    // Any return to the accepted level drops the count back to zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s != level_q) begin
            if (cnt_q == CNT_MAX) level_d = s;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

module key_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MODE_COUNT      = 4
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 RESET,
    key_mode_sequencer_if.slave  bus
);
    localparam logic [1:0] MODE_MAX = 2'(MODE_COUNT - 1);

    logic [1:0] key_state;
    logic       prev0_q;
    logic [1:0] mode_q, mode_d;
    logic       step_q, step_d;
    logic       clear_q, clear_d;
    logic       press0;

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_mode_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (MAX10_CLK1_50),
            .rst_i   (RESET),
            .key_n_i (bus.KEY[i]),
            .level_o (key_state[i])
        );
    end

    assign press0 = key_state[0] & ~prev0_q;

    // KEY1 is sampled on the same cycle as the press edge, so a simultaneous
    // debounce of both keys resolves to a clear.
    always_comb begin
        mode_d  = mode_q;
        step_d  = 1'b0;
        clear_d = 1'b0;
        if (press0) begin
            if (key_state[1]) begin
                mode_d  = 2'd0;
                clear_d = 1'b1;
            end else begin
                mode_d  = (mode_q == MODE_MAX) ? 2'd0 : mode_q + 2'd1;
                step_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            prev0_q <= 1'b0;
            mode_q  <= 2'd0;
            step_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            prev0_q <= key_state[0];
            mode_q  <= mode_d;
            step_q  <= step_d;
            clear_q <= clear_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.key_state   = key_state;
    assign bus.step_pulse  = step_q;
    assign bus.clear_pulse = clear_q;
endmodule

// File: tb/tb_key_mode_sequencer.sv
// Bench for key_mode_sequencer with DEBOUNCE_CYCLES=4: table of KEY levels with
// expected mode/key_state, plus a strobe scoreboard keyed on cycle number.
module tb_key_mode_sequencer;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    typedef struct {
        logic [1:0] key;
        int         hold;
        bit         evt;
        bit         clr;
        logic [1:0] exp_mode;
        logic [1:0] exp_ks;
    } vec_t;

    typedef struct {
        bit         clr;
        logic [1:0] mode;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];
    exp_t sb[$];

    key_mode_sequencer_if bus();

    key_mode_sequencer #(.DEBOUNCE_CYCLES(DB), .MODE_COUNT(4)) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (rst),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance one clock and compare any strobe against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.step_pulse || bus.clear_pulse) begin
            check("strobe_exclusive", int'(bus.step_pulse & bus.clear_pulse), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'({bus.clear_pulse, bus.step_pulse}), 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", int'(bus.clear_pulse), int'(e.clr));
                check("strobe_mode", int'(bus.mode), int'(e.mode));
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic add(input logic [1:0] key, input int hold, input bit evt, input bit clr,
                       input logic [1:0] m, input logic [1:0] ks);
        vec_t v;
        v.key = key; v.hold = hold; v.evt = evt; v.clr = clr; v.exp_mode = m; v.exp_ks = ks;
        vecs.push_back(v);
    endtask

    task automatic expect_evt(input bit clr, input logic [1:0] m, input int at);
        exp_t e;
        e.clr = clr; e.mode = m; e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        int r;
        cyc = 0; n_checks = 0; n_fail = 0;

        // idle release, then five clean steps
        add(2'b11, 10, 0, 0, 2'd0, 2'b00);
        add(2'b10, 10, 1, 0, 2'd1, 2'b01); add(2'b11, 10, 0, 0, 2'd1, 2'b00);
        add(2'b10, 10, 1, 0, 2'd2, 2'b01); add(2'b11, 10, 0, 0, 2'd2, 2'b00);
        add(2'b10, 10, 1, 0, 2'd3, 2'b01); add(2'b11, 10, 0, 0, 2'd3, 2'b00);
        add(2'b10, 10, 1, 0, 2'd0, 2'b01); add(2'b11, 10, 0, 0, 2'd0, 2'b00);
        add(2'b10, 10, 1, 0, 2'd1, 2'b01); add(2'b11, 10, 0, 0, 2'd1, 2'b00);
        // bounce that settles high: nothing accepted
        for (int i = 0; i < 3; i++) begin
            add(2'b10, 2, 0, 0, 2'd1, 2'b00); add(2'b11, 2, 0, 0, 2'd1, 2'b00);
        end
        add(2'b11, 10, 0, 0, 2'd1, 2'b00);
        // bounce that settles low: exactly one step
        for (int i = 0; i < 3; i++) begin
            add(2'b10, 2, 0, 0, 2'd1, 2'b00); add(2'b11, 2, 0, 0, 2'd1, 2'b00);
        end
        add(2'b10, 10, 1, 0, 2'd2, 2'b01); add(2'b11, 10, 0, 0, 2'd2, 2'b00);
        add(2'b10, 10, 1, 0, 2'd3, 2'b01); add(2'b11, 10, 0, 0, 2'd3, 2'b00);
        // clear with KEY1 held, then KEY1 release leaves mode 0
        add(2'b01, 10, 0, 0, 2'd3, 2'b10);
        add(2'b00, 10, 1, 1, 2'd0, 2'b11);
        add(2'b10, 10, 0, 0, 2'd0, 2'b01);
        add(2'b11, 10, 0, 0, 2'd0, 2'b00);
        // simultaneous press of both keys resolves to a clear
        add(2'b10, 10, 1, 0, 2'd1, 2'b01); add(2'b11, 10, 0, 0, 2'd1, 2'b00);
        add(2'b00, 10, 1, 1, 2'd0, 2'b11); add(2'b11, 10, 0, 0, 2'd0, 2'b00);

        // reset held with both keys pressed
        rst = 1'b1;
        bus.KEY = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mode", int'(bus.mode), 0);
            check("rst_key_state", int'(bus.key_state), 0);
            check("rst_strobes", int'({bus.step_pulse, bus.clear_pulse}), 0);
        end
        rst = 1'b0;
        r = cyc;
        expect_evt(1'b1, 2'd0, r + LAT);
        ticks(DB + 1);
        check("held_ks_before", int'(bus.key_state), 0);
        tick();
        check("held_ks_rise", int'(bus.key_state), 3);
        ticks(4);
        check("held_mode", int'(bus.mode), 0);

        foreach (vecs[k]) begin
            bus.KEY = vecs[k].key;
            if (vecs[k].evt) expect_evt(vecs[k].clr, vecs[k].exp_mode, cyc + LAT);
            ticks(vecs[k].hold);
            check($sformatf("vec%0d_mode", k), int'(bus.mode), int'(vecs[k].exp_mode));
            check($sformatf("vec%0d_ks", k), int'(bus.key_state), int'(vecs[k].exp_ks));
        end

        // reset pulse while the KEY0 debounce count sits at 2
        bus.KEY = 2'b10;
        ticks(4);
        rst = 1'b1;
        tick();
        check("mid_rst_ks", int'(bus.key_state), 0);
        check("mid_rst_mode", int'(bus.mode), 0);
        rst = 1'b0;
        r = cyc;
        expect_evt(1'b0, 2'd1, r + LAT);
        ticks(DB + 1);
        check("mid_ks_before", int'(bus.key_state), 0);
        tick();
        check("mid_ks_rise", int'(bus.key_state), 1);
        ticks(3);
        check("mid_mode", int'(bus.mode), 1);
        bus.KEY = 2'b11;
        ticks(10);
        check("mid_release_mode", int'(bus.mode), 1);

        ticks(10);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
